// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-time limit; gnt_idx/gnt_valid drive a 3-to-8 decoder.
// A grant ends on rel, on loss of the grantee's request, or after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_next;
    logic [2:0] ptr, ptr_next;
    logic [7:0] hcnt, hcnt_next;
    logic [7:0] gnt_next;
    logic [2:0] gnt_idx_next;
    logic       gnt_valid_next;
    logic       timeout_next;

    logic [2:0] winner;
    logic       hold_done;
    logic       grantee_req;
    logic       release_now;

    // Scan from the highest offset down so the last hit is the one closest to ptr.
    always_comb begin
        winner = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                winner = ptr + 3'(i);
            end
        end
    end

    assign hold_done   = (hcnt == HOLD_LAST);
    assign grantee_req = req[gnt_idx];
    assign release_now = rel | ~grantee_req | hold_done;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next     = state;
        ptr_next       = ptr;
        hcnt_next      = hcnt;
        gnt_next       = gnt;
        gnt_idx_next   = gnt_idx;
        gnt_valid_next = gnt_valid;
        timeout_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_next     = GRANT;
                    gnt_idx_next   = winner;
                    gnt_valid_next = 1'b1;
                    gnt_next       = 8'b1 << winner;
                    hcnt_next      = 8'd0;
                end
            end
            GRANT: begin
                hcnt_next = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
                if (release_now) begin
                    state_next     = IDLE;
                    gnt_valid_next = 1'b0;
                    gnt_next       = 8'd0;
                    ptr_next       = gnt_idx + 3'd1;
                    // Only a pure hold-limit expiry counts as a forced release.
                    timeout_next   = hold_done & ~rel & grantee_req;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hcnt      <= 8'd0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            hcnt      <= hcnt_next;
            gnt       <= gnt_next;
            gnt_idx   <= gnt_idx_next;
            gnt_valid <= gnt_valid_next;
            timeout   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD=4): a hand-derived vector table fed through
// an expected-value queue, plus a bounded hold-limit sequence.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rel;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic l,
                       input logic [7:0] g, input logic [2:0] x, input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.rel = l; e.gnt = g; e.idx = x; e.valid = v; e.to = t;
        vecs.push_back(e);
    endtask

    // Drive one cycle of inputs away from the active edge, then sample #1 after it.
    task automatic step(input logic r, input logic [7:0] q, input logic l);
        @(negedge clk);
        rst = r;
        req = q;
        rel = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   hold_cycles;
        logic saw_to;
        logic [7:0] onehot;

        rst = 1'b1;
        req = 8'd0;
        rel = 1'b0;

        //   rst  req    rel   gnt    idx  val  to
        add(1, 8'hFF, 0, 8'h00, 0, 0, 0);  // reset held with all requests
        add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(0, 8'hFF, 0, 8'h01, 0, 1, 0);  // first grant one cycle after reset
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);  // request drop, ptr=1
        add(1, 8'h00, 0, 8'h00, 0, 0, 0);  // reset back to ptr=0
        add(0, 8'h05, 0, 8'h01, 0, 1, 0);  // basic rotation
        add(0, 8'h05, 1, 8'h00, 0, 0, 0);
        add(0, 8'h05, 0, 8'h04, 2, 1, 0);
        add(0, 8'h05, 1, 8'h00, 2, 0, 0);  // ptr=3
        add(0, 8'h03, 0, 8'h01, 0, 1, 0);  // wrap 3..7 -> 0
        add(0, 8'h03, 1, 8'h00, 0, 0, 0);
        add(0, 8'h03, 0, 8'h02, 1, 1, 0);
        add(0, 8'h00, 1, 8'h00, 1, 0, 0);  // rel plus drop, ptr=2
        add(0, 8'h00, 1, 8'h00, 1, 0, 0);  // rel in IDLE ignored
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);  // hold-limit grant, cycle 1
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);  // cycle 4
        add(0, 8'h10, 0, 8'h00, 4, 0, 1);  // forced release pulse, ptr=5
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);  // regranted after one idle cycle
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 1, 8'h00, 4, 0, 0);  // rel with hold limit: no timeout
        add(0, 8'h22, 0, 8'h20, 5, 1, 0);  // ptr=5 picks 5
        add(0, 8'h02, 0, 8'h00, 5, 0, 0);  // req[5] drop, ptr=6
        add(0, 8'h02, 0, 8'h02, 1, 1, 0);  // pending req[1]
        add(0, 8'hFF, 0, 8'h02, 1, 1, 0);  // new requests ignored in GRANT
        add(0, 8'hFF, 1, 8'h00, 1, 0, 0);  // ptr=2
        add(0, 8'h40, 0, 8'h40, 6, 1, 0);
        add(1, 8'h40, 0, 8'h00, 0, 0, 0);  // reset mid-grant
        add(0, 8'hC1, 0, 8'h01, 0, 1, 0);  // ptr back to 0
        add(0, 8'hC1, 1, 8'h00, 0, 0, 0);
        add(0, 8'hC1, 0, 8'h40, 6, 1, 0);
        add(0, 8'hC1, 1, 8'h00, 6, 0, 0);
        add(0, 8'hC1, 0, 8'h80, 7, 1, 0);
        add(0, 8'hC1, 1, 8'h00, 7, 0, 0);  // ptr wraps 7 -> 0
        add(0, 8'hC1, 0, 8'h01, 0, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            e.id = i; e.gnt = vecs[i].gnt; e.idx = vecs[i].idx;
            e.valid = vecs[i].valid; e.to = vecs[i].to;
            sb.push_back(e);
            step(vecs[i].rst, vecs[i].req, vecs[i].rel);
            e = sb.pop_front();
            check($sformatf("v%0d gnt", e.id), 32'(gnt), 32'(e.gnt));
            check($sformatf("v%0d gnt_idx", e.id), 32'(gnt_idx), 32'(e.idx));
            check($sformatf("v%0d gnt_valid", e.id), 32'(gnt_valid), 32'(e.valid));
            check($sformatf("v%0d timeout", e.id), 32'(timeout), 32'(e.to));
            onehot = gnt_valid ? (8'b1 << gnt_idx) : 8'h00;
            check($sformatf("v%0d gnt_consistent", e.id), 32'(gnt), 32'(onehot));
        end

        // ptr=1 here; hold req[3] and count grant cycles until the forced release.
        step(0, 8'h08, 0);
        check("hold first grant", 32'(gnt), 32'h08);
        hold_cycles = 0;
        saw_to = 1'b0;
        for (int c = 0; c < 20 && gnt_valid; c++) begin
            hold_cycles++;
            step(0, 8'h08, 0);
        end
        saw_to = timeout;
        check("hold cycles", 32'(hold_cycles), 32'(MAX_HOLD));
        check("hold timeout pulse", 32'(saw_to), 32'd1);
        check("hold released gnt", 32'(gnt), 32'h00);
        step(0, 8'h08, 0);
        check("hold pulse one cycle", 32'(timeout), 32'd0);
        check("hold regrant", 32'(gnt), 32'h08);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
